// File: rtl/pe_os_acc_drain_if.sv
// Result drain port of the output-stationary PE: valid/ready with a registered payload.
// The sat_flag member exists only when PE_ACC_SAT_EN is defined.
interface pe_os_acc_drain_if #(
    parameter int ACCWIDTH = 20
) ();
    logic [ACCWIDTH-1:0] res_out;
    logic                res_vld;
    logic                res_rdy;
`ifdef PE_ACC_SAT_EN
    logic                sat_flag;
`endif

    // A result transfers on a rising edge where res_vld && res_rdy; res_out is stable while res_vld waits.
    modport master (
        output res_out,
        output res_vld,
`ifdef PE_ACC_SAT_EN
        output sat_flag,
`endif
        input  res_rdy
    );

    modport slave (
        input  res_out,
        input  res_vld,
`ifdef PE_ACC_SAT_EN
        input  sat_flag,
`endif
        output res_rdy
    );
endinterface

// File: rtl/pe_os_acc_drain.sv
// Output-stationary systolic PE: forwards A/B operands, accumulates a K_len-long dot product, drains via valid/ready.
// Optional macro PE_ACC_SAT_EN: saturating accumulation plus sticky sat_flag on the drain port.
module pe_os_acc_drain #(
    parameter int DATAWIDTH = 8,
    parameter int ACCWIDTH  = 2*DATAWIDTH+4,
    parameter int KWIDTH    = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [DATAWIDTH-1:0] A_in,
    input  logic                 A_vld_in,
    input  logic [DATAWIDTH-1:0] B_in,
    input  logic                 B_vld_in,
    output logic [DATAWIDTH-1:0] Next_A,
    output logic                 Next_A_vld,
    output logic [DATAWIDTH-1:0] Next_B,
    output logic                 Next_B_vld,
    input  logic                 start,
    input  logic [KWIDTH-1:0]    K_len,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic [1:0]           state_dbg,
    pe_os_acc_drain_if.master    drain
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;

    state_t              state, state_next;
    logic [ACCWIDTH-1:0] acc, acc_next, acc_sum, res_q, res_next, prod, a_x, b_x;
    logic [KWIDTH-1:0]   cnt, cnt_next, k_len_q, k_next;
    logic                signed_q, sm_next, fire, do_load;
`ifdef PE_ACC_SAT_EN
    logic                sat_q, sat_next, clamp;
    logic [ACCWIDTH:0]   usum;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Next_A     <= '0;
            Next_A_vld <= 1'b0;
            Next_B     <= '0;
            Next_B_vld <= 1'b0;
        end else begin
            Next_A     <= A_in;
            Next_A_vld <= A_vld_in;
            Next_B     <= B_in;
            Next_B_vld <= B_vld_in;
        end
    end

    // Extending operands to ACCWIDTH before multiplying gives the full product modulo 2^ACCWIDTH.
    assign a_x  = {{(ACCWIDTH-DATAWIDTH){signed_q & A_in[DATAWIDTH-1]}}, A_in};
    assign b_x  = {{(ACCWIDTH-DATAWIDTH){signed_q & B_in[DATAWIDTH-1]}}, B_in};
    assign prod = a_x * b_x;
    assign fire = A_vld_in && B_vld_in && (state == ACC);

`ifdef PE_ACC_SAT_EN
    always_comb begin
        usum    = {1'b0, acc} + {1'b0, prod};
        acc_sum = usum[ACCWIDTH-1:0];
        clamp   = 1'b0;
        if (signed_q) begin
            if ((acc[ACCWIDTH-1] == prod[ACCWIDTH-1]) && (usum[ACCWIDTH-1] != acc[ACCWIDTH-1])) begin
                clamp   = 1'b1;
                acc_sum = acc[ACCWIDTH-1] ? {1'b1, {(ACCWIDTH-1){1'b0}}} : {1'b0, {(ACCWIDTH-1){1'b1}}};
            end
        end else if (usum[ACCWIDTH]) begin
            clamp   = 1'b1;
            acc_sum = '1;
        end
    end
`else
    assign acc_sum = acc + prod;
`endif

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        k_next     = k_len_q;
        sm_next    = signed_q;
        res_next   = res_q;
        do_load    = 1'b0;
`ifdef PE_ACC_SAT_EN
        sat_next   = sat_q;
`endif
        case (state)
            IDLE: do_load = start;
            ACC: begin
                if (start) begin
                    do_load = 1'b1;
                end else if (fire) begin
                    acc_next = acc_sum;
                    cnt_next = cnt + KWIDTH'(1);
`ifdef PE_ACC_SAT_EN
                    sat_next = sat_q | clamp;
`endif
                    if (cnt_next == k_len_q) begin
                        state_next = HOLD;
                        res_next   = acc_sum;
                    end
                end
            end
            HOLD: begin
                if (drain.res_rdy) begin
                    do_load    = start;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A new tile overrides whatever the case arm chose; zero length finishes at once.
        if (do_load) begin
            k_next   = K_len;
            sm_next  = signed_mode;
            acc_next = '0;
            cnt_next = '0;
`ifdef PE_ACC_SAT_EN
            sat_next = 1'b0;
`endif
            if (K_len == '0) begin
                state_next = HOLD;
                res_next   = '0;
            end else begin
                state_next = ACC;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            k_len_q  <= '0;
            signed_q <= 1'b0;
            res_q    <= '0;
`ifdef PE_ACC_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            k_len_q  <= k_next;
            signed_q <= sm_next;
            res_q    <= res_next;
`ifdef PE_ACC_SAT_EN
            sat_q    <= sat_next;
`endif
        end
    end

    assign drain.res_out = res_q;
    assign drain.res_vld = (state == HOLD);
`ifdef PE_ACC_SAT_EN
    assign drain.sat_flag = sat_q;
`endif
    assign busy      = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: doc/pe_os_acc_drain.md
Name: pe_os_acc_drain

Overview:
- Parametrised output-stationary systolic processing element, successor to the fixed 8-bit multiply-accumulate PE.
- Forwards operands east (A) and south (B) with a one-cycle register stage and per-operand valid bits.
- Accumulates a programmable-length dot product with signed/unsigned selection.
- Presents the finished result through a valid/ready drain port, so a row/column controller can unload the array while the next tile starts.

Parameters:
- DATAWIDTH, 8, operand width in bits.
- ACCWIDTH, 2*DATAWIDTH+4 (=20), accumulator and result width; must be >= 2*DATAWIDTH.
- KWIDTH, 8, width of the accumulation-length field; maximum tile depth is 2^KWIDTH-1.

Ports:
- CLK  input  1  clock, rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- A_in  input  DATAWIDTH  west operand.
- A_vld_in  input  1  A_in valid.
- B_in  input  DATAWIDTH  north operand.
- B_vld_in  input  1  B_in valid.
- Next_A  output  DATAWIDTH  registered A_in to east neighbour.
- Next_A_vld  output  1  registered A_vld_in.
- Next_B  output  DATAWIDTH  registered B_in to south neighbour.
- Next_B_vld  output  1  registered B_vld_in.
- start  input  1  one-cycle pulse: clear accumulator, begin new tile.
- K_len  input  KWIDTH  number of operand pairs in tile; sampled with start.
- signed_mode  input  1  1 = two's-complement operands; sampled with start.
- res_out  output  ACCWIDTH  accumulated result.
- res_vld  output  1  res_out valid.
- res_rdy  input  1  downstream accepts result.
- busy  output  1  high in ACC or HOLD.

Behaviour:
- Reset (async, RSTn=0): Next_A/Next_B=0, Next_A_vld/Next_B_vld=0, acc=0, cnt=0, res_out=0, res_vld=0, busy=0, state=IDLE.
- Forwarding: Next_A/Next_A_vld/Next_B/Next_B_vld register their inputs every cycle, independent of state. Latency is exactly 1 cycle.
- Fire condition: A_vld_in && B_vld_in while state=ACC.
  - A single valid (mismatch) never accumulates.
  - Operands outside ACC are forwarded but not accumulated.
- Product width rules:
  - Full 2*DATAWIDTH product.
  - signed_mode=1: sign-extended to ACCWIDTH.
  - signed_mode=0: zero-extended to ACCWIDTH.
  - acc wraps modulo 2^ACCWIDTH.
- States:
  - IDLE: on start, latch K_len/signed_mode, clear acc and cnt, go to ACC. Operands in the start cycle are ignored. If K_len=0, go to HOLD with acc=0.
  - ACC: on fire, acc += product and cnt += 1. When the fire makes cnt==K_len, go to HOLD next edge. res_vld rises the cycle after the last fire, with res_out equal to the final acc.
  - HOLD: res_vld=1 and res_out stable until res_rdy.
    - res_rdy=1 without start: go to IDLE, res_vld=0 next cycle.
    - res_rdy=1 with start in the same cycle: hand off, then go directly to ACC with cleared acc. No idle bubble.
    - start without res_rdy: ignored. The result is never lost.
- start in ACC: restart with newly sampled K_len/signed_mode. A fire in that cycle is discarded. cnt=0.
- res_out is registered and updates only on entry to HOLD. Outside HOLD it holds its last value.
- busy = (state != IDLE).
- Reset mid-tile: immediate return to reset values. A partial sum is discarded.

Optional Feature:
- Macro PE_ACC_SAT_EN.
- Defined:
  - Accumulation saturates instead of wrapping.
  - signed_mode=1 clamps to [-2^(ACCWIDTH-1), 2^(ACCWIDTH-1)-1].
  - signed_mode=0 clamps to [0, 2^ACCWIDTH-1].
  - Adds output sat_flag (1 bit): sticky per tile, set on any clamp, cleared by start, reset 0, valid alongside res_vld.
- Undefined: modulo wrap; no sat_flag port.

Test Plan:
- Forwarding: A_in=0x5A/vld=1 at cycle t -> Next_A=0x5A, Next_A_vld=1 at t+1. Same for B. Holds in every state.
- Unsigned tile: start with K_len=3, signed_mode=0; pairs (3,4), (255,255), (1,1) on consecutive cycles -> res_vld one cycle after the third pair, res_out=12+65025+1=65038.
- Signed tile and stalls: start with K_len=2, signed_mode=1; pairs (-2,5) and (-128,-128), with a mismatched-valid cycle between them -> res_out=-10+16384=16374. The mismatch cycle does not count.
- Backpressure and hand-off: hold res_rdy=0 for 5 cycles -> res_out stable, res_vld=1. Assert res_rdy with start (K_len=1) in the same cycle -> next result = only the new pair's product. No bubble.
- Edge cases:
  - K_len=0 -> res_out=0.
  - start in ACC after 2 fires -> earlier sum discarded.
  - RSTn low mid-tile -> all outputs 0 asynchronously.
- PE_ACC_SAT_EN: ACCWIDTH=20, signed, 40 pairs of (-128,-128) -> res_out=524287, sat_flag=1. Without the macro -> wrapped value 655360 mod 2^20 = 655360 (0xA0000).
